// File: rtl/ram_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer for the single-port processor RAM.
// Latency: ram_en one cycle after the request is sampled in IDLE; ack and rdata three cycles after.
// Backpressure: requests are held by the requester until its ack; alternating priority on contention.
module ram_arbiter #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_req,
    input  logic [ADDRESS_SIZE-1:0] fetch_addr,
    output logic                    fetch_ack,
    output logic [DATA_SIZE-1:0]    fetch_rdata,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [ADDRESS_SIZE-1:0] data_addr,
    input  logic [DATA_SIZE-1:0]    data_wdata,
    output logic                    data_ack,
    output logic [DATA_SIZE-1:0]    data_rdata,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDRESS_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0]    ram_wdata,
    input  logic [DATA_SIZE-1:0]    ram_rdata,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_t;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    state_t state, next_state;
    logic   grant;
    logic   last_grant;
    logic   is_write;
    logic   pick_data;
    logic   start;

    always_comb begin
        next_state = state;
        // The data port wins unless fetch is also asking and data was served last.
        pick_data  = data_req && (!fetch_req || last_grant == FETCH);
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    start      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = RESP;
            RESP:    next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= FETCH;
            last_grant  <= FETCH;
            is_write    <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                grant      <= pick_data;
                last_grant <= pick_data;
                is_write   <= pick_data && data_we;
                ram_addr   <= pick_data ? data_addr : fetch_addr;
                if (pick_data && data_we) begin
                    ram_wdata <= data_wdata;
                end
            end
            if (state == RESP && !is_write) begin
                if (grant == DATA) begin
                    data_rdata <= ram_rdata;
                end else begin
                    fetch_rdata <= ram_rdata;
                end
            end
        end
    end

    assign ram_en    = (state == ISSUE);
    assign ram_we    = (state == ISSUE) && is_write;
    assign fetch_ack = (state == ACK) && (grant == FETCH);
    assign data_ack  = (state == ACK) && (grant == DATA);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM (one-cycle read latency).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_dat;
    logic [31:0] mem [0:65535];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_SIZE(32), .ADDRESS_SIZE(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_dat  = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        tick();
        preload(16'h0004, 32'hDEADBEEF);
        preload(16'h0020, 32'hAAAA0001);
        preload(16'h0030, 32'hBBBB0002);
        tick();
        reset = 1'b0;
        vec_cnt++;
        if ({ram_en, ram_we, fetch_ack, data_ack, busy} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 00000", {ram_en, ram_we, fetch_ack, data_ack, busy});
        end
        vec_cnt++;
        if ({ram_addr, ram_wdata, fetch_rdata, data_rdata} !== 112'h0) begin
            err_cnt++;
            $display("FAIL reset_regs: got %h %h %h %h expected all zero", ram_addr, ram_wdata, fetch_rdata, data_rdata);
        end
    endtask

    task automatic test_single_fetch;
        fetch_req = 1'b1; fetch_addr = 16'h0004;
        tick();
        vec_cnt++;
        if ({ram_en, ram_we, busy, ram_addr} !== {3'b101, 16'h0004}) begin
            err_cnt++;
            $display("FAIL fetch_issue: got en=%b we=%b busy=%b addr=%h expected 1 0 1 0004", ram_en, ram_we, busy, ram_addr);
        end
        tick();
        vec_cnt++;
        if ({ram_en, ram_we, fetch_ack} !== 3'b000) begin
            err_cnt++;
            $display("FAIL fetch_resp: got en/we/ack=%b expected 000", {ram_en, ram_we, fetch_ack});
        end
        tick();
        vec_cnt++;
        if ({fetch_ack, data_ack, fetch_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            err_cnt++;
            $display("FAIL fetch_ack: got acks=%b rdata=%h expected 10 deadbeef", {fetch_ack, data_ack}, fetch_rdata);
        end
        fetch_req = 1'b0;
        tick();
        vec_cnt++;
        if ({fetch_ack, busy, fetch_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            err_cnt++;
            $display("FAIL fetch_after: got ack=%b busy=%b rdata=%h expected 0 0 deadbeef", fetch_ack, busy, fetch_rdata);
        end
    endtask

    task automatic test_store_load;
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0010; data_wdata = 32'h12345678;
        tick();
        vec_cnt++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h0010, 32'h12345678}) begin
            err_cnt++;
            $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h", ram_en, ram_we, ram_addr, ram_wdata);
        end
        tick();
        tick();
        vec_cnt++;
        if ({data_ack, fetch_ack, data_rdata} !== {2'b10, 32'h0}) begin
            err_cnt++;
            $display("FAIL store_ack: got acks=%b rdata=%h expected 10 00000000", {data_ack, fetch_ack}, data_rdata);
        end
        vec_cnt++;
        if (mem[16'h0010] !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL store_mem: got %h expected 12345678", mem[16'h0010]);
        end
        data_we = 1'b0; data_wdata = 32'hFFFFFFFF;
        tick();
        tick();
        vec_cnt++;
        if ({ram_en, ram_we} !== 2'b10) begin
            err_cnt++;
            $display("FAIL load_issue: got en/we=%b expected 10", {ram_en, ram_we});
        end
        tick();
        tick();
        vec_cnt++;
        if ({data_ack, data_rdata} !== {1'b1, 32'h12345678}) begin
            err_cnt++;
            $display("FAIL load_ack: got ack=%b rdata=%h expected 1 12345678", data_ack, data_rdata);
        end
        data_req = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        logic exp_d, exp_f;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_req = 1'b1; fetch_addr = 16'h0020;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0030;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_d = (k == 3) || (k == 11);
            exp_f = (k == 7);
            vec_cnt++;
            if ({data_ack, fetch_ack} !== {exp_d, exp_f}) begin
                err_cnt++;
                $display("FAIL contend_ack cycle %0d: got d/f=%b%b expected %b%b", k, data_ack, fetch_ack, exp_d, exp_f);
            end
            if (k == 1 || k == 5 || k == 9) begin
                vec_cnt++;
                if (ram_addr !== ((k == 5) ? 16'h0020 : 16'h0030)) begin
                    err_cnt++;
                    $display("FAIL contend_grant cycle %0d: got addr=%h", k, ram_addr);
                end
            end
        end
        vec_cnt++;
        if ({fetch_rdata, data_rdata} !== {32'hAAAA0001, 32'hBBBB0002}) begin
            err_cnt++;
            $display("FAIL contend_rdata: got %h %h expected aaaa0001 bbbb0002", fetch_rdata, data_rdata);
        end
        fetch_req = 1'b0; data_req = 1'b0;
        tick();
    endtask

    task automatic test_input_change;
        fetch_req = 1'b1; fetch_addr = 16'h0004;
        tick();
        tick();
        fetch_addr = 16'h0008;
        vec_cnt++;
        if (ram_addr !== 16'h0004) begin
            err_cnt++;
            $display("FAIL change_resp_addr: got %h expected 0004", ram_addr);
        end
        tick();
        vec_cnt++;
        if ({fetch_ack, ram_addr, fetch_rdata} !== {1'b1, 16'h0004, 32'hDEADBEEF}) begin
            err_cnt++;
            $display("FAIL change_ack: got ack=%b addr=%h rdata=%h expected 1 0004 deadbeef", fetch_ack, ram_addr, fetch_rdata);
        end
        fetch_req = 1'b0;
        tick();
        vec_cnt++;
        if ({busy, ram_addr} !== {1'b0, 16'h0004}) begin
            err_cnt++;
            $display("FAIL change_idle: got busy=%b addr=%h expected 0 0004", busy, ram_addr);
        end
    endtask

    task automatic test_reset_mid;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0010;
        tick();
        tick();
        reset = 1'b1; data_req = 1'b0;
        tick();
        reset = 1'b0;
        vec_cnt++;
        if ({busy, data_ack, fetch_ack, ram_en, fetch_rdata, data_rdata} !== 68'h0) begin
            err_cnt++;
            $display("FAIL rstmid_state: got busy=%b acks=%b en=%b rdata=%h %h expected all zero",
                     busy, {data_ack, fetch_ack}, ram_en, fetch_rdata, data_rdata);
        end
        tick();
        vec_cnt++;
        if ({busy, data_ack, fetch_ack} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rstmid_noack: got busy/acks=%b expected 000", {busy, data_ack, fetch_ack});
        end
        data_req = 1'b1;
        tick();
        tick();
        tick();
        vec_cnt++;
        if ({data_ack, data_rdata} !== {1'b1, 32'h12345678}) begin
            err_cnt++;
            $display("FAIL rstmid_reissue: got ack=%b rdata=%h expected 1 12345678", data_ack, data_rdata);
        end
        data_req = 1'b0;
        tick();
    endtask

    task automatic test_idle;
        for (int k = 0; k < 20; k++) begin
            tick();
            vec_cnt++;
            if ({ram_en, busy, fetch_ack, data_ack, ram_addr} !== {4'b0000, 16'h0010}) begin
                err_cnt++;
                $display("FAIL idle cycle %0d: got en=%b busy=%b acks=%b addr=%h expected 0 0 00 0010",
                         k, ram_en, busy, {fetch_ack, data_ack}, ram_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_input_change();
        test_reset_mid();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
